// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: PC source select, sequencer states
// and instruction size.
package cpu_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_REG    = 2'b10,
    PC_JUMP   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-address generation: sequential, branch, register and jump
// targets formed from the current PC, plus the misalignment flag.
module pc_target_gen
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CHECK_ALIGN = 1
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        pc_src_i,
  input  logic [ADDR_W-1:0] in_register_i,
  input  logic [15:0]       offset_i,
  input  logic [25:0]       index_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              misaligned_o
);

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] branch;
  logic [ADDR_W-1:0] jump;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] raw;

  assign seq        = pc_i + ADDR_W'(INSTR_BYTES);
  assign branch_off = {{(ADDR_W-18){offset_i[15]}}, offset_i, 2'b00};
  assign branch     = seq + branch_off;
  assign pc_plus4_o = seq;

  // At ADDR_W=28 the index fills the whole address; no PC region bits remain.
  if (ADDR_W == 28) begin : g_jump_narrow
    assign jump = {index_i, 2'b00};
  end else begin : g_jump_wide
    assign jump = {seq[ADDR_W-1:28], index_i, 2'b00};
  end

  always_comb begin
    raw = seq;
    case (pc_src_i)
      PC_SEQ:    raw = seq;
      PC_BRANCH: raw = branch;
      PC_REG:    raw = in_register_i;
      PC_JUMP:   raw = jump;
      default:   raw = seq;
    endcase
  end

  always_comb begin
    target_o     = raw;
    misaligned_o = 1'b0;
    if (CHECK_ALIGN != 0) begin
      misaligned_o = (raw[1:0] != 2'b00);
    end else begin
      target_o[1:0] = 2'b00;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit for the multicycle CPU: PC register, strobe-gated update,
// and sticky halt / misalignment-fault states.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal operation, pc follows the strobes
//   ST_HALTED | halt requested; pc frozen until Reset
//   ST_FAULT  | misaligned target requested; pc and fault record frozen
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          CHECK_ALIGN = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              Zero,
  input  logic              BranchNe,
  input  logic [1:0]        PCSrc,
  input  logic [ADDR_W-1:0] inRegister,
  input  logic [15:0]       offset,
  input  logic [25:0]       index,
  input  logic              Halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] faultPC,
  output logic [ADDR_W-1:0] faultTarget
);

  if (ADDR_W < 28 || ADDR_W > 32) begin : g_bad_addr_w
    $error("pc_sequencer: ADDR_W must be in 28..32");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("pc_sequencer: RESET_PC must be a multiple of 4");
  end

  localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];

  pc_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] fault_pc_q;
  logic [ADDR_W-1:0] fault_target_q;
  logic              halted_q;
  logic              fault_q;

  logic [ADDR_W-1:0] pc_d;
  logic              misaligned;
  logic              take;

  pc_target_gen #(
    .ADDR_W      (ADDR_W),
    .CHECK_ALIGN (CHECK_ALIGN)
  ) u_target_gen (
    .pc_i          (pc_q),
    .pc_src_i      (PCSrc),
    .in_register_i (inRegister),
    .offset_i      (offset),
    .index_i       (index),
    .pc_plus4_o    (pcPlus4),
    .target_o      (pc_d),
    .misaligned_o  (misaligned)
  );

  // PCWrite alone is enough to take, so it naturally dominates PCWriteCond.
  assign take = PCWrite | (PCWriteCond & (Zero ^ BranchNe));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC_W;
      fault_pc_q     <= '0;
      fault_target_q <= '0;
      halted_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Halt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (take && misaligned) begin
            state_q        <= ST_FAULT;
            fault_q        <= 1'b1;
            fault_pc_q     <= pc_q;
            fault_target_q <= pc_d;
          end else if (take) begin
            pc_q <= pc_d;
          end
        end
        ST_FAULT: begin
          if (Halt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign faultPC     = fault_pc_q;
  assign faultTarget = fault_target_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for single-cycle behaviour,
// hand sequences for fault, halt, 28-bit wrap and unchecked alignment.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Zero;
  logic        BranchNe;
  logic [1:0]  PCSrc;
  logic [31:0] inRegister;
  logic [15:0] offset;
  logic [25:0] index;
  logic        Halt;

  logic [31:0] pc_a, pcp4_a, fpc_a, ftg_a;
  logic        halted_a, fault_a;
  logic [27:0] pc_b, pcp4_b, fpc_b, ftg_b;
  logic        halted_b, fault_b;
  logic [31:0] pc_c, pcp4_c, fpc_c, ftg_c;
  logic        halted_c, fault_c;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .CHECK_ALIGN(1)) dut_a (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Zero(Zero), .BranchNe(BranchNe), .PCSrc(PCSrc), .inRegister(inRegister),
    .offset(offset), .index(index), .Halt(Halt),
    .pc(pc_a), .pcPlus4(pcp4_a), .halted(halted_a), .fault(fault_a),
    .faultPC(fpc_a), .faultTarget(ftg_a));

  pc_sequencer #(.ADDR_W(28), .RESET_PC(32'h0), .CHECK_ALIGN(1)) dut_b (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Zero(Zero), .BranchNe(BranchNe), .PCSrc(PCSrc), .inRegister(inRegister[27:0]),
    .offset(offset), .index(index), .Halt(Halt),
    .pc(pc_b), .pcPlus4(pcp4_b), .halted(halted_b), .fault(fault_b),
    .faultPC(fpc_b), .faultTarget(ftg_b));

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h100), .CHECK_ALIGN(0)) dut_c (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Zero(Zero), .BranchNe(BranchNe), .PCSrc(PCSrc), .inRegister(inRegister),
    .offset(offset), .index(index), .Halt(Halt),
    .pc(pc_c), .pcPlus4(pcp4_c), .halted(halted_c), .fault(fault_c),
    .faultPC(fpc_c), .faultTarget(ftg_c));

  typedef struct {
    logic        rst;
    logic        pcw;
    logic        pcwc;
    logic        zero;
    logic        bne;
    logic [1:0]  src;
    logic [31:0] inreg;
    logic [15:0] off;
    logic [25:0] idx;
    logic        halt;
    logic [31:0] exp_pc;
    logic        exp_h;
    logic        exp_f;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    Reset = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; Zero = 1'b0; BranchNe = 1'b0;
    PCSrc = 2'b00; inRegister = '0; offset = '0; index = '0; Halt = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle(); Reset = 1'b1; step(); Reset = 1'b0;
  endtask

  task automatic load_reg(input logic [31:0] v);
    idle(); PCWrite = 1'b1; PCSrc = 2'b10; inRegister = v; step(); idle();
  endtask

  initial begin
    //          rst pcw pcwc z  bne src    inreg          off       idx        halt exp_pc        h  f
    vecs[0]  = '{1, 0, 0, 0, 0, 2'b00, 32'h0,         16'h0,    26'h0,     0, 32'h0000_0000, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 2'b00, 32'h0,         16'h0,    26'h0,     0, 32'h0000_0004, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 2'b00, 32'h0,         16'h0,    26'h0,     0, 32'h0000_0008, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 2'b00, 32'h0,         16'h0,    26'h0,     0, 32'h0000_000C, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 2'b10, 32'h100,       16'h0,    26'h0,     0, 32'h0000_0100, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 0, 2'b01, 32'h0,         16'hFFFE, 26'h0,     0, 32'h0000_00FC, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 2'b10, 32'h100,       16'h0,    26'h0,     0, 32'h0000_0100, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 2'b01, 32'h0,         16'hFFFE, 26'h0,     0, 32'h0000_0100, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 1, 2'b01, 32'h0,         16'hFFFE, 26'h0,     0, 32'h0000_00FC, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 1, 2'b01, 32'h0,         16'hFFFE, 26'h0,     0, 32'h0000_00FC, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 2'b10, 32'h3000_0010, 16'h0,    26'h0,     0, 32'h3000_0010, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 2'b11, 32'h0,         16'h0,    26'h40,    0, 32'h3000_0100, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 2'b10, 32'h0040_0000, 16'h0,    26'h0,     0, 32'h0040_0000, 0, 0};
    vecs[13] = '{0, 1, 1, 0, 0, 2'b00, 32'h0,         16'h0,    26'h0,     0, 32'h0040_0004, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 0, 2'b11, 32'h0,         16'h0,    26'h3FF,   0, 32'h0040_0004, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 0, 2'b01, 32'h0,         16'h0003, 26'h0,     0, 32'h0040_0014, 0, 0};

    idle();
    step();
    for (int i = 0; i < NVEC; i++) begin
      Reset = vecs[i].rst; PCWrite = vecs[i].pcw; PCWriteCond = vecs[i].pcwc;
      Zero = vecs[i].zero; BranchNe = vecs[i].bne; PCSrc = vecs[i].src;
      inRegister = vecs[i].inreg; offset = vecs[i].off; index = vecs[i].idx;
      Halt = vecs[i].halt;
      step();
      chk($sformatf("vec%0d_pc", i), pc_a, vecs[i].exp_pc);
      chk($sformatf("vec%0d_pcplus4", i), pcp4_a, vecs[i].exp_pc + 32'd4);
      chk($sformatf("vec%0d_halted", i), {31'b0, halted_a}, {31'b0, vecs[i].exp_h});
      chk($sformatf("vec%0d_fault", i), {31'b0, fault_a}, {31'b0, vecs[i].exp_f});
    end
    idle();

    // Misaligned register target: fault recorded, pc frozen, sticky through halt.
    do_reset();
    load_reg(32'h40);
    chk("flt_pre_pc", pc_a, 32'h40);
    PCWrite = 1'b1; PCSrc = 2'b10; inRegister = 32'h202; step(); idle();
    chk("flt_pc", pc_a, 32'h40);
    chk("flt_fault", {31'b0, fault_a}, 32'h1);
    chk("flt_faultpc", fpc_a, 32'h40);
    chk("flt_faulttarget", ftg_a, 32'h202);
    chk("flt_halted", {31'b0, halted_a}, 32'h0);
    PCWrite = 1'b1; PCSrc = 2'b00; step();
    PCWrite = 1'b1; PCSrc = 2'b10; inRegister = 32'h500; step(); idle();
    chk("flt_hold_pc", pc_a, 32'h40);
    chk("flt_hold_faultpc", fpc_a, 32'h40);
    chk("flt_hold_faulttarget", ftg_a, 32'h202);
    Halt = 1'b1; step(); idle();
    chk("flt_halt_halted", {31'b0, halted_a}, 32'h1);
    chk("flt_halt_fault", {31'b0, fault_a}, 32'h1);
    do_reset();
    chk("flt_rst_pc", pc_a, 32'h0);
    chk("flt_rst_fault", {31'b0, fault_a}, 32'h0);
    chk("flt_rst_halted", {31'b0, halted_a}, 32'h0);
    chk("flt_rst_faultpc", fpc_a, 32'h0);
    chk("flt_rst_faulttarget", ftg_a, 32'h0);

    // Halt beats a simultaneous take; strobes then ignored until reset.
    PCWrite = 1'b1; step(); idle();
    chk("hlt_pre_pc", pc_a, 32'h4);
    Halt = 1'b1; PCWrite = 1'b1; step(); idle();
    chk("hlt_pc", pc_a, 32'h4);
    chk("hlt_halted", {31'b0, halted_a}, 32'h1);
    PCWrite = 1'b1; PCSrc = 2'b10; inRegister = 32'h300; step();
    PCWriteCond = 1'b1; PCWrite = 1'b0; Zero = 1'b1; PCSrc = 2'b01; step(); idle();
    chk("hlt_hold_pc", pc_a, 32'h4);
    chk("hlt_hold_halted", {31'b0, halted_a}, 32'h1);
    chk("hlt_fault", {31'b0, fault_a}, 32'h0);
    Reset = 1'b1; PCWrite = 1'b1; step(); idle();
    chk("hlt_rst_pc", pc_a, 32'h0);
    chk("hlt_rst_halted", {31'b0, halted_a}, 32'h0);

    // 28-bit instance: pcPlus4 wrap and full-width jump.
    do_reset();
    load_reg(32'h0FFF_FFFC);
    chk("w28_pc", {4'b0, pc_b}, 32'h0FFF_FFFC);
    chk("w28_pcplus4", {4'b0, pcp4_b}, 32'h0);
    PCWrite = 1'b1; PCSrc = 2'b00; step(); idle();
    chk("w28_wrap_pc", {4'b0, pc_b}, 32'h0);
    PCWrite = 1'b1; PCSrc = 2'b11; index = 26'h3FF_FFFF; step(); idle();
    chk("w28_jump_pc", {4'b0, pc_b}, 32'h0FFF_FFFC);

    // Unchecked instance: non-zero reset PC, low bits masked, never faults.
    do_reset();
    chk("na_rst_pc", pc_c, 32'h100);
    load_reg(32'h202);
    chk("na_mask_pc", pc_c, 32'h200);
    chk("na_fault", {31'b0, fault_c}, 32'h0);
    PCWrite = 1'b1; PCSrc = 2'b10; inRegister = 32'h0000_1233; step(); idle();
    chk("na_mask2_pc", pc_c, 32'h0000_1230);
    chk("na_faulttarget", ftg_c, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
